// File: rtl/rs_stream_aligner.sv
// rs_stream_aligner: framing and alignment stage for the streaming RS decoder.
// Counts received symbols into N-symbol frames, buffers each symbol until its
// error value returns from the correction chain, then emits the corrected
// symbol with frame markers and status.
//
// Ports:
//   CLK, RESET        clock; asynchronous active-high reset
//   in_valid/in_sym   received symbol stream; in_ready = buffer not full
//   sym_idx           frame index of the next symbol to be accepted
//   frame_done        one-cycle pulse after the last symbol of a frame is accepted
//   err_valid/err_sym error value for the oldest buffered symbol (pops it)
//   err_fail          uncorrectable flag, qualified by err_valid
//   corr_en           1 = apply correction, 0 = pass raw symbol
//   clr_flags         synchronous clear of overflow/underflow
//   out_*             registered corrected symbol, sof/eof markers, fail status
//   fill              buffer occupancy
//   overflow          sticky: write attempted while full
//   underflow         sticky: error value presented while empty
module rs_stream_aligner #(
  parameter int unsigned SYM_W = 4,
  parameter int unsigned N     = 15,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           in_sym,
  output logic                       in_ready,
  output logic [$clog2(N)-1:0]       sym_idx,
  output logic                       frame_done,
  input  logic                       err_valid,
  input  logic [SYM_W-1:0]           err_sym,
  input  logic                       err_fail,
  input  logic                       corr_en,
  input  logic                       clr_flags,
  output logic                       out_valid,
  output logic [SYM_W-1:0]           out_sym,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic                       out_fail,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SYM_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] out_idx;
  logic             wr_c;
  logic             rd_c;
  logic [SYM_W-1:0] head_c;
  logic [SYM_W-1:0] corr_c;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Frame index advance with wrap at N.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Readiness comes from registered fill only, so a same-cycle pop never
  // frees space for a write.
  assign in_ready = (fill != FILL_W'(DEPTH));
  assign wr_c     = in_valid && in_ready;
  assign rd_c     = err_valid && (fill != '0);
  assign head_c   = mem[rd_ptr];
  assign corr_c   = (corr_en && !err_fail) ? err_sym : '0;

  // Symbol storage; contents need no reset since pointers define validity.
  always_ff @(posedge CLK) begin
    if (wr_c) begin
      mem[wr_ptr] <= in_sym;
    end
  end

  // Input side: write pointer, frame index and frame-complete pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      sym_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr_c && (sym_idx == IDX_W'(N - 1));
      if (wr_c) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        sym_idx <= idx_inc(sym_idx);
      end
    end
  end

  // Output side: pop head, apply correction, tag frame position.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr    <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_fail  <= 1'b0;
    end else begin
      out_valid <= rd_c;
      if (rd_c) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        out_idx  <= idx_inc(out_idx);
        out_sym  <= head_c ^ corr_c;
        out_fail <= err_fail;
        out_sof  <= (out_idx == '0);
        out_eof  <= (out_idx == IDX_W'(N - 1));
      end
    end
  end

  // Occupancy and sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fill      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({wr_c, rd_c})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
      overflow  <= (in_valid && !in_ready) || (overflow && !clr_flags);
      underflow <= (err_valid && (fill == '0)) || (underflow && !clr_flags);
    end
  end

endmodule

// File: tb/tb_rs_stream_aligner.sv
// Testbench for rs_stream_aligner: table-driven frame vectors, hand-written
// overflow/underflow/reset sequences, and randomized traffic against a
// queue-based reference model.
module tb_rs_stream_aligner;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned N     = 15;
  localparam int unsigned DEPTH = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             in_ready;
  logic [3:0]       sym_idx;
  logic             frame_done;
  logic             err_valid;
  logic [SYM_W-1:0] err_sym;
  logic             err_fail;
  logic             corr_en;
  logic             clr_flags;
  logic             out_valid;
  logic [SYM_W-1:0] out_sym;
  logic             out_sof;
  logic             out_eof;
  logic             out_fail;
  logic [5:0]       fill;
  logic             overflow;
  logic             underflow;

  rs_stream_aligner #(.SYM_W(SYM_W), .N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready),
    .sym_idx(sym_idx), .frame_done(frame_done),
    .err_valid(err_valid), .err_sym(err_sym), .err_fail(err_fail),
    .corr_en(corr_en), .clr_flags(clr_flags),
    .out_valid(out_valid), .out_sym(out_sym), .out_sof(out_sof),
    .out_eof(out_eof), .out_fail(out_fail), .fill(fill),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int dut_out_cnt = 0;

  // Reference model: a FIFO of symbols plus running accept/pop counts.
  logic [SYM_W-1:0] q[$];
  int unsigned      n_acc;
  int unsigned      n_pop;
  logic             m_ovf, m_unf, m_fd, m_ovalid;
  logic [SYM_W-1:0] m_osym;
  logic             m_osof, m_oeof, m_ofail;

  typedef struct {
    logic [SYM_W-1:0] in_sym;
    logic [SYM_W-1:0] err_sym;
    logic             corr_en;
    logic             err_fail;
    logic [SYM_W-1:0] exp_sym;
    logic             exp_sof;
    logic             exp_eof;
    logic             exp_fail;
  } vec_t;

  vec_t tbl[45];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_acc    = 0;
    n_pop    = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_fd     = 1'b0;
    m_ovalid = 1'b0;
    m_osym   = '0;
    m_osof   = 1'b0;
    m_oeof   = 1'b0;
    m_ofail  = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_sym    = '0;
    err_valid = 1'b0;
    err_sym   = '0;
    err_fail  = 1'b0;
    corr_en   = 1'b0;
    clr_flags = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic cycle(input logic iv, input logic [SYM_W-1:0] isym,
                       input logic ev, input logic [SYM_W-1:0] esym,
                       input logic ef, input logic ce, input logic clr);
    logic             acc, rd;
    logic [SYM_W-1:0] h;
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    acc = iv && (q.size() != DEPTH);
    rd  = ev && (q.size() != 0);
    in_valid = iv; in_sym = isym; err_valid = ev; err_sym = esym;
    err_fail = ef; corr_en = ce; clr_flags = clr;

    m_fd     = acc && ((n_acc % N) == N - 1);
    m_ovalid = rd;
    if (rd) begin
      h       = q.pop_front();
      m_osym  = (ce && !ef) ? (h ^ esym) : h;
      m_ofail = ef;
      m_osof  = ((n_pop % N) == 0);
      m_oeof  = ((n_pop % N) == N - 1);
      n_pop++;
    end
    if (acc) begin
      q.push_back(isym);
      n_acc++;
    end
    if (iv && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (ev && !rd)  m_unf = 1'b1;
    else if (clr)   m_unf = 1'b0;

    @(posedge CLK);
    #1;
    if (out_valid === 1'b1) dut_out_cnt++;
    chk("out_valid",  32'(out_valid),  32'(m_ovalid));
    chk("out_sym",    32'(out_sym),    32'(m_osym));
    chk("out_sof",    32'(out_sof),    32'(m_osof));
    chk("out_eof",    32'(out_eof),    32'(m_oeof));
    chk("out_fail",   32'(out_fail),   32'(m_ofail));
    chk("fill",       32'(fill),       32'(q.size()));
    chk("sym_idx",    32'(sym_idx),    n_acc % N);
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("underflow",  32'(underflow),  32'(m_unf));
    idle_inputs();
  endtask

  initial begin
    int unsigned acc_base, out_base;

    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 15; i++) begin
        tbl[m*15+i].in_sym   = 4'(i + 1);
        tbl[m*15+i].err_sym  = (i == 3) ? 4'h5 : 4'h0;
        tbl[m*15+i].corr_en  = (m != 1);
        tbl[m*15+i].err_fail = (m == 2);
        tbl[m*15+i].exp_sym  = (m == 0 && i == 3) ? 4'h1 : 4'(i + 1);
        tbl[m*15+i].exp_sof  = (i == 0);
        tbl[m*15+i].exp_eof  = (i == 14);
        tbl[m*15+i].exp_fail = (m == 2);
      end
    end

    // Reset values.
    idle_inputs();
    RESET = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_sym",    32'(out_sym),    32'd0);
    chk("rst_sym_idx",    32'(sym_idx),    32'd0);
    chk("rst_fill",       32'(fill),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_underflow",  32'(underflow),  32'd0);
    RESET = 1'b0;

    // Three frames of the fixed vector set: corrected, raw, and uncorrectable.
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 15; i++) begin
        if (m == 0) chk("tbl_sym_idx", 32'(sym_idx), i);
        cycle(1'b1, tbl[m*15+i].in_sym, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        if (m == 0) chk("tbl_frame_done", 32'(frame_done), 32'(i == 14));
      end
      chk("tbl_fill_full", 32'(fill), 32'd15);
      if (m == 0) begin
        chk("tbl_idx_wrap", 32'(sym_idx), 32'd0);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("tbl_frame_done_drop", 32'(frame_done), 32'd0);
      end
      for (int i = 0; i < 15; i++) begin
        cycle(1'b0, 4'h0, 1'b1, tbl[m*15+i].err_sym, tbl[m*15+i].err_fail,
              tbl[m*15+i].corr_en, 1'b0);
        chk("tbl_out_sym",  32'(out_sym),  32'(tbl[m*15+i].exp_sym));
        chk("tbl_out_sof",  32'(out_sof),  32'(tbl[m*15+i].exp_sof));
        chk("tbl_out_eof",  32'(out_eof),  32'(tbl[m*15+i].exp_eof));
        chk("tbl_out_fail", 32'(out_fail), 32'(tbl[m*15+i].exp_fail));
      end
      chk("tbl_fill_empty", 32'(fill), 32'd0);
    end

    // Fill to DEPTH, overflow attempt, then pop and simultaneous pop+push.
    for (int i = 0; i < 32; i++) cycle(1'b1, 4'(i), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_fill",     32'(fill),     32'd32);
    cycle(1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set",     32'(overflow), 32'd1);
    chk("ovf_sym_idx", 32'(sym_idx),  32'(32 % 15));
    cycle(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("pop_fill", 32'(fill), 32'd31);
    cycle(1'b1, 4'hC, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("rw_fill", 32'(fill), 32'd31);
    cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 31; i++) cycle(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_fill", 32'(fill), 32'd0);

    // Underflow on an empty buffer.
    cycle(1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    chk("unf_set",       32'(underflow), 32'd1);
    chk("unf_out_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame discards everything.
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'(i + 8), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b1;
    #2;
    chk("mid_rst_fill_async", 32'(fill), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    chk("mid_rst_fill",    32'(fill),    32'd0);
    chk("mid_rst_sym_idx", 32'(sym_idx), 32'd0);
    cycle(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_idx_next", 32'(sym_idx), 32'd1);
    cycle(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_out_sym", 32'(out_sym), 32'h9);
    chk("mid_rst_out_sof", 32'(out_sof), 32'd1);

    // Randomized traffic: 4 frames with gaps on both sides.
    acc_base = n_acc;
    out_base = dut_out_cnt;
    for (int c = 0; c < 3000 && (dut_out_cnt - out_base) < 60; c++) begin
      logic iv, ev, ef, ce;
      iv = ((n_acc - acc_base) < 60) && ($urandom_range(0, 2) != 0);
      ev = (q.size() != 0) && ($urandom_range(0, 1) != 0);
      ef = ($urandom_range(0, 7) == 0);
      ce = ($urandom_range(0, 3) != 0);
      cycle(iv, 4'($urandom), ev, 4'($urandom), ef, ce, 1'b0);
    end
    chk("rand_out_count", dut_out_cnt - out_base, 32'd60);
    chk("rand_fill_end",  32'(fill), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_stream_aligner.md
Name: rs_stream_aligner

Overview:
- Parametrised framing and alignment stage for the streaming RS decoder datapath. Replaces a fixed-length delay line with a handshaked symbol buffer.
- Accepts received symbols and counts them into N-symbol frames. Emits the symbol index and a frame-complete pulse for the syndrome/Euclid chain.
- Buffers each symbol until its error symbol returns, then outputs the corrected symbol with frame markers and status.
- Sits between the channel input, the syndrome/Euclid/error-positioning chain, and the decoder output.

Parameters:
SYM_W, 4, symbol width in bits (GF(2^SYM_W)).
N, 15, symbols per codeword frame.
DEPTH, 32, buffer depth in symbols; must be >= N plus the correction chain's latency in symbols.

Ports:
CLK  input  1  clock.
RESET  input  1  reset RESET, asynchronous, active-high.
in_valid  input  1  received symbol present.
in_sym  input  SYM_W  received symbol.
in_ready  output  1  buffer can accept a symbol (not full).
sym_idx  output  clog2(N)  index (0..N-1) of the next symbol to be accepted.
frame_done  output  1  one-cycle pulse, cycle after the Nth symbol of a frame is accepted.
err_valid  input  1  error symbol present, in stream order.
err_sym  input  SYM_W  error value for the oldest buffered symbol.
err_fail  input  1  decoder-uncorrectable flag, qualified by err_valid.
corr_en  input  1  1 = apply correction; 0 = pass raw symbol through.
clr_flags  input  1  synchronous clear of the sticky flags.
out_valid  output  1  output symbol valid.
out_sym  output  SYM_W  corrected symbol.
out_sof  output  1  out_sym is symbol 0 of its frame.
out_eof  output  1  out_sym is symbol N-1 of its frame.
out_fail  output  1  err_fail registered alongside out_sym.
fill  output  clog2(DEPTH+1)  buffer occupancy.
overflow  output  1  sticky: in_valid asserted while in_ready=0.
underflow  output  1  sticky: err_valid asserted while buffer empty.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Pointers, fill, and both index counters are 0. RESET mid-frame discards all buffered symbols and partial frame state.
- Write (accept): in_valid && in_ready. Symbol goes to the write pointer, which wraps at DEPTH.
- in_ready = (fill != DEPTH), computed from registered fill. A read in the same cycle does not free space for that cycle's write.
- sym_idx increments on each accept and wraps N-1 -> 0. On the accept with sym_idx == N-1, frame_done is 1 in the following cycle only. Back-to-back frames give pulses exactly N accepts apart. Gaps in in_valid stretch the frame without resetting it.
- Read: err_valid && fill != 0. The head symbol is popped; the read pointer wraps at DEPTH.
- Registered output, latency one cycle after the read:
  - out_valid = 1.
  - out_sym = head XOR ((corr_en && !err_fail) ? err_sym : 0).
  - out_fail = err_fail.
  - out_sof = (out index == 0); out_eof = (out index == N-1).
  - The out index counts pops and wraps at N.
- Cycles with no read: out_valid = 0. out_sym, out_sof, out_eof and out_fail hold their previous values.
- Simultaneous write and read: fill is unchanged. The empty-buffer case is covered by the underflow rule (no fall-through).
- Overflow: in_valid with in_ready = 0. The symbol is dropped, sym_idx does not advance, and overflow sets.
- Underflow: err_valid with fill = 0. No output, the out index does not advance, and underflow sets.
- Sticky flags are cleared only by RESET or clr_flags. If clr_flags and a new event occur in the same cycle, the set wins.
- fill is always in 0..DEPTH. It changes by +1 on write only, -1 on read only, and 0 otherwise.

Test Plan:
- Reset, then 15 consecutive accepts of symbols 0x1..0xF -> sym_idx steps 0..14 and wraps to 0; frame_done is high in exactly the cycle after the 15th accept; fill = 15.
- Continue from that buffer, then 15 err_valid with err_sym = 0x0 except 0x5 at index 3, corr_en=1 -> out_sym equals the input except symbol 3 = 0x4 ^ 0x5 = 0x1; out_sof on the first output, out_eof on the 15th; fill returns to 0.
- Same buffer contents and error symbols with corr_en=0, and separately with err_fail=1 -> raw symbols out unchanged; out_fail = 1 in the err_fail case.
- 32 accepts with no reads -> in_ready = 0, fill = 32. A 33rd in_valid -> overflow = 1 and the symbol is absent from later output. Then one read and one write in the same cycle -> fill stays at 31 on the next cycle. clr_flags -> overflow = 0.
- err_valid while empty -> underflow = 1, out_valid = 0. Separately, write 7 symbols, assert RESET mid-frame, then release -> fill = 0, sym_idx = 0, and the next accepted symbol has index 0.
- Random gaps on in_valid and err_valid over 4 frames -> output stream equals input XOR errors, in order, with no loss and with sof/eof every 15 symbols.
